ex_bus_demux: RTL and testbench
===============================

Name: ex_bus_demux

Overview:
- Drives the external MSX cartridge bus through a narrow, time-multiplexed 8-bit pin group: address low byte, then address high byte (each captured by an external latch), then the data phase.
- Sits between the internal Z80 bus (bus_addr, bus_data, bus_mreq_n/iorq_n/rd_n/wr_n) and the ex_bus_* pads.
- All logic runs on clk_108m.
- Exports state_demux, counter_demux and latch_demux for the on-chip logic analyzer.

Parameters:
- STAGE_CYCLES, 8: clk_108m cycles per phase (ADDR_LO, ADDR_HI, read sample point); legal range 4..31.
- LATCH_SETUP, 2: counter value at which the latch strobe rises; must be >=1.
- LATCH_PULSE, 3: latch strobe width in cycles; LATCH_SETUP+LATCH_PULSE must be < STAGE_CYCLES.

Ports:
- clk_108m  in  1  system clock
- reset  in  1  asynchronous, active-high
- bus_addr  in  16  internal CPU address
- bus_data_in  in  8  CPU write data
- bus_mreq_n  in  1  memory request, active-low
- bus_iorq_n  in  1  I/O request, active-low
- bus_rd_n  in  1  read strobe, active-low
- bus_wr_n  in  1  write strobe, active-low
- bus_data_out  out  8  captured external read data
- bus_data_valid  out  1  one-cycle pulse when bus_data_out updates
- ex_bus_data_o  out  8  value driven onto the external pin group
- ex_bus_data_i  in  8  value sampled from the external pin group
- ex_bus_data_oe  out  1  1 = FPGA drives the pins
- ex_bus_data_reverse_n  out  1  transceiver direction; 0 = external to FPGA
- latch_demux  out  1  strobe for the address-low latch, active-high
- latch_demux_hi  out  1  strobe for the address-high latch, active-high
- state_demux  out  2  current state, debug
- counter_demux  out  5  phase counter, debug

Behaviour:
- All inputs are synchronous to clk_108m; no synchronisers are required.
- req = (!bus_mreq_n | !bus_iorq_n) & (!bus_rd_n | !bus_wr_n). Refresh cycles (mreq without rd/wr) are ignored.
- On the first cycle req is high in IDLE, bus_addr, bus_data_in and the write flag (!bus_wr_n) are registered.
- States and encodings:
  - IDLE = 0: waits for req.
  - ADDR_LO = 1, ADDR_HI = 2, DATA = 3.
- Transitions:
  - IDLE -> ADDR_LO on req. counter_demux = 0.
  - ADDR_LO -> ADDR_HI when counter = STAGE_CYCLES-1. Counter returns to 0.
  - ADDR_HI -> DATA when counter = STAGE_CYCLES-1. Counter returns to 0.
  - DATA -> IDLE when req is low.
- counter_demux increments each cycle inside a state. In DATA it saturates at STAGE_CYCLES-1.
- ADDR_LO:
  - ex_bus_data_o = addr[7:0], oe = 1, reverse_n = 1.
  - latch_demux = 1 for counter in [LATCH_SETUP, LATCH_SETUP+LATCH_PULSE-1].
- ADDR_HI: same as ADDR_LO with addr[15:8], using latch_demux_hi.
- DATA, write:
  - ex_bus_data_o = registered write data, oe = 1, reverse_n = 1, held until req falls.
  - bus_data_valid is never asserted.
- DATA, read:
  - oe = 0, reverse_n = 0.
  - At counter = STAGE_CYCLES-1 (first occurrence only), ex_bus_data_i is registered into bus_data_out.
  - bus_data_valid pulses high exactly the following cycle.
- Latency from the first req-high cycle T to the valid pulse: read valid at T+1+3*STAGE_CYCLES (T+25 with defaults).
- Abort: if req falls in ADDR_LO, ADDR_HI, or DATA before the read sample, go to IDLE next cycle. In that case:
  - both strobes low, oe = 0, no valid pulse;
  - bus_data_out keeps its old value.
- Back-to-back cycles: req still high on return to IDLE does not restart; a new transfer needs req low for at least 1 cycle.
- IDLE outputs: ex_bus_data_o = 0x00, oe = 0, reverse_n = 1, both strobes 0.
- Strobes are registered and glitch-free; never both high; never high outside their own state.
- Reset (asynchronous, any state including mid-transfer):
  - state 0, counter 0;
  - ex_bus_data_o = 0x00, oe = 0, reverse_n = 1;
  - latch_demux = 0, latch_demux_hi = 0;
  - bus_data_out = 0x00, bus_data_valid = 0.

Test Plan:
- Read, defaults: bus_addr = 0x4A5B, mreq_n = 0, rd_n = 0 held 40 cycles; ex_bus_data_i = 0xC3.
  -> ex_bus_data_o = 0x5B with latch_demux high at cycles T+3..T+5.
  -> ex_bus_data_o = 0x4A with latch_demux_hi high at T+11..T+13.
  -> reverse_n = 0 from T+17; bus_data_out = 0xC3 with valid pulse at T+25 only.
- I/O write: bus_addr = 0x0098, iorq_n = 0, wr_n = 0, bus_data_in = 0x7E held 30 cycles.
  -> address phases as above; DATA drives 0x7E with oe = 1 until req falls, then IDLE and oe = 0.
  -> no valid pulse.
- Refresh: mreq_n = 0 with rd_n = wr_n = 1 for 20 cycles -> state_demux stays 0, strobes never assert.
- Abort: read with req dropped at T+10 -> IDLE at T+11; latch_demux_hi never rises; no valid pulse; bus_data_out unchanged.
- Reset mid-transfer: assert reset at T+12 (latch_demux_hi high) -> same-cycle asynchronous return to all reset values; first transfer after release behaves as the first scenario.
- Back-to-back: two reads separated by 1 idle cycle, data 0x11 then 0x22 -> two valid pulses 26 cycles apart, bus_data_out 0x11 then 0x22.

Source files
------------

// File: rtl/ex_bus_demux.sv
// Purpose: drives the MSX cartridge bus over a shared 8-bit pin group in three phases: address low, address high, then data.
// Latency: read data appears on bus_data_out with a one-cycle valid pulse 1+3*STAGE_CYCLES cycles after the first request cycle.
// Backpressure: none. The transfer holds in DATA while req stays high, and any drop of req returns to IDLE on the next cycle.
//
// Ports:
//   clk_108m, reset                    clock; asynchronous active-high reset
//   bus_addr/bus_data_in/bus_*_n       internal Z80 bus request side
//   bus_data_out, bus_data_valid       captured read data and its one-cycle update pulse
//   ex_bus_data_o/_i/_oe/_reverse_n    external pin group and transceiver control
//   latch_demux, latch_demux_hi        address latch strobes (registered)
//   state_demux, counter_demux         debug taps for the logic analyzer
module ex_bus_demux #(
    parameter int STAGE_CYCLES = 8,
    parameter int LATCH_SETUP  = 2,
    parameter int LATCH_PULSE  = 3
) (
    input  logic        clk_108m,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_data_in,
    input  logic        bus_mreq_n,
    input  logic        bus_iorq_n,
    input  logic        bus_rd_n,
    input  logic        bus_wr_n,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_valid,
    output logic [7:0]  ex_bus_data_o,
    input  logic [7:0]  ex_bus_data_i,
    output logic        ex_bus_data_oe,
    output logic        ex_bus_data_reverse_n,
    output logic        latch_demux,
    output logic        latch_demux_hi,
    output logic [1:0]  state_demux,
    output logic [4:0]  counter_demux
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_LO = 2'd1,
        ADDR_HI = 2'd2,
        DATA    = 2'd3
    } state_t;

    localparam logic [4:0] LAST      = 5'(STAGE_CYCLES - 1);
    localparam logic [4:0] LAT_FIRST = 5'(LATCH_SETUP);
    localparam logic [4:0] LAT_LAST  = 5'(LATCH_SETUP + LATCH_PULSE - 1);

    state_t      state, state_nxt;
    logic [4:0]  counter, counter_nxt;
    logic        req, req_prev, start, sample;
    logic [15:0] addr_q, addr_nxt;
    logic [7:0]  wdata_q, wdata_nxt;
    logic        wr_q, wr_nxt;
    logic        sampled;

    logic [7:0]  data_o_nxt;
    logic        oe_nxt, rev_nxt, lat_nxt, lat_hi_nxt;

    // Refresh (mreq with neither rd nor wr) never forms a request.
    assign req = (!bus_mreq_n || !bus_iorq_n) && (!bus_rd_n || !bus_wr_n);

    // A transfer only starts on a rising request, so a request still held
    // when we come back to IDLE cannot retrigger.
    assign start = (state == IDLE) && req && !req_prev;

    // Read data is taken once, at the end of the DATA stage, and only if
    // the CPU is still requesting at that point.
    assign sample = (state == DATA) && !wr_q && !sampled && req && (counter == LAST);

    assign addr_nxt  = start ? bus_addr    : addr_q;
    assign wdata_nxt = start ? bus_data_in : wdata_q;
    assign wr_nxt    = start ? !bus_wr_n   : wr_q;

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        case (state)
            IDLE: begin
                counter_nxt = 5'd0;
                if (start) state_nxt = ADDR_LO;
            end
            ADDR_LO: begin
                if (!req) begin
                    state_nxt   = IDLE;
                    counter_nxt = 5'd0;
                end else if (counter == LAST) begin
                    state_nxt   = ADDR_HI;
                    counter_nxt = 5'd0;
                end else begin
                    counter_nxt = counter + 5'd1;
                end
            end
            ADDR_HI: begin
                if (!req) begin
                    state_nxt   = IDLE;
                    counter_nxt = 5'd0;
                end else if (counter == LAST) begin
                    state_nxt   = DATA;
                    counter_nxt = 5'd0;
                end else begin
                    counter_nxt = counter + 5'd1;
                end
            end
            DATA: begin
                if (!req) begin
                    state_nxt   = IDLE;
                    counter_nxt = 5'd0;
                end else if (counter != LAST) begin
                    counter_nxt = counter + 5'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                counter_nxt = 5'd0;
            end
        endcase
    end

    // Pin-side outputs are decoded from the next state/counter and then
    // registered, so they line up with state_demux/counter_demux and the
    // strobes leave the flops glitch-free.
    always_comb begin
        data_o_nxt = 8'h00;
        oe_nxt     = 1'b0;
        rev_nxt    = 1'b1;
        lat_nxt    = 1'b0;
        lat_hi_nxt = 1'b0;
        case (state_nxt)
            ADDR_LO: begin
                data_o_nxt = addr_nxt[7:0];
                oe_nxt     = 1'b1;
                lat_nxt    = (counter_nxt >= LAT_FIRST) && (counter_nxt <= LAT_LAST);
            end
            ADDR_HI: begin
                data_o_nxt = addr_nxt[15:8];
                oe_nxt     = 1'b1;
                lat_hi_nxt = (counter_nxt >= LAT_FIRST) && (counter_nxt <= LAT_LAST);
            end
            DATA: begin
                if (wr_nxt) begin
                    data_o_nxt = wdata_nxt;
                    oe_nxt     = 1'b1;
                end else begin
                    rev_nxt    = 1'b0;
                end
            end
            default: begin
                data_o_nxt = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_108m or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            counter               <= 5'd0;
            req_prev              <= 1'b0;
            addr_q                <= 16'h0000;
            wdata_q               <= 8'h00;
            wr_q                  <= 1'b0;
            sampled               <= 1'b0;
            bus_data_out          <= 8'h00;
            bus_data_valid        <= 1'b0;
            ex_bus_data_o         <= 8'h00;
            ex_bus_data_oe        <= 1'b0;
            ex_bus_data_reverse_n <= 1'b1;
            latch_demux           <= 1'b0;
            latch_demux_hi        <= 1'b0;
        end else begin
            state                 <= state_nxt;
            counter               <= counter_nxt;
            req_prev              <= req;
            addr_q                <= addr_nxt;
            wdata_q               <= wdata_nxt;
            wr_q                  <= wr_nxt;
            bus_data_valid        <= sample;
            ex_bus_data_o         <= data_o_nxt;
            ex_bus_data_oe        <= oe_nxt;
            ex_bus_data_reverse_n <= rev_nxt;
            latch_demux           <= lat_nxt;
            latch_demux_hi        <= lat_hi_nxt;
            if (start) begin
                sampled <= 1'b0;
            end else if (sample) begin
                sampled <= 1'b1;
            end
            if (sample) begin
                bus_data_out <= ex_bus_data_i;
            end
        end
    end

    assign state_demux   = state;
    assign counter_demux = counter;

endmodule

// File: tb/tb_ex_bus_demux.sv
module tb_ex_bus_demux;

    localparam int S  = 8;
    localparam int LS = 2;
    localparam int LP = 3;

    logic        clk_108m = 1'b0;
    logic        reset;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_in;
    logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n;
    logic [7:0]  bus_data_out;
    logic        bus_data_valid;
    logic [7:0]  ex_bus_data_o;
    logic [7:0]  ex_bus_data_i;
    logic        ex_bus_data_oe, ex_bus_data_reverse_n;
    logic        latch_demux, latch_demux_hi;
    logic [1:0]  state_demux;
    logic [4:0]  counter_demux;

    int checks   = 0;
    int failures = 0;

    ex_bus_demux #(.STAGE_CYCLES(S), .LATCH_SETUP(LS), .LATCH_PULSE(LP)) dut (
        .clk_108m              (clk_108m),
        .reset                 (reset),
        .bus_addr              (bus_addr),
        .bus_data_in           (bus_data_in),
        .bus_mreq_n            (bus_mreq_n),
        .bus_iorq_n            (bus_iorq_n),
        .bus_rd_n              (bus_rd_n),
        .bus_wr_n              (bus_wr_n),
        .bus_data_out          (bus_data_out),
        .bus_data_valid        (bus_data_valid),
        .ex_bus_data_o         (ex_bus_data_o),
        .ex_bus_data_i         (ex_bus_data_i),
        .ex_bus_data_oe        (ex_bus_data_oe),
        .ex_bus_data_reverse_n (ex_bus_data_reverse_n),
        .latch_demux           (latch_demux),
        .latch_demux_hi        (latch_demux_hi),
        .state_demux           (state_demux),
        .counter_demux         (counter_demux)
    );

    always #5 clk_108m = ~clk_108m;

    // Reference model: k counts cycles since the transfer's first request
    // cycle (0 = idle). Every expected output follows from k by the phase
    // arithmetic: k in 1..S address low, S+1..2S address high, then data.
    int          k = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic        m_wr = 1'b0;
    logic [7:0]  m_dout = '0;
    logic        m_valid = 1'b0;
    logic        m_req_prev = 1'b0;

    always @(posedge clk_108m or posedge reset) begin
        if (reset) begin
            k = 0; m_dout = 8'h00; m_valid = 1'b0; m_req_prev = 1'b0;
        end else begin
            logic req;
            req = (!bus_mreq_n || !bus_iorq_n) && (!bus_rd_n || !bus_wr_n);
            m_valid = 1'b0;
            if (k == 0) begin
                if (req && !m_req_prev) begin
                    k = 1; m_addr = bus_addr; m_wr = !bus_wr_n; m_wdata = bus_data_in;
                end
            end else if (!req) begin
                k = 0;
            end else begin
                if (!m_wr && k == 3 * S) begin
                    m_dout = ex_bus_data_i; m_valid = 1'b1;
                end
                if (k < 1000) k++;
            end
            m_req_prev = req;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk_108m) begin
        int e_st, e_cnt, e_dat, e_oe, e_rev, e_lat, e_hi;
        e_st = 0; e_cnt = 0; e_dat = 0; e_oe = 0; e_rev = 1; e_lat = 0; e_hi = 0;
        if (k >= 1 && k <= S) begin
            e_st = 1; e_cnt = k - 1; e_dat = int'(m_addr[7:0]); e_oe = 1;
            e_lat = (e_cnt >= LS && e_cnt <= LS + LP - 1) ? 1 : 0;
        end else if (k > S && k <= 2 * S) begin
            e_st = 2; e_cnt = k - S - 1; e_dat = int'(m_addr[15:8]); e_oe = 1;
            e_hi = (e_cnt >= LS && e_cnt <= LS + LP - 1) ? 1 : 0;
        end else if (k > 2 * S) begin
            e_st = 3; e_cnt = (k - 2 * S - 1 < S - 1) ? k - 2 * S - 1 : S - 1;
            if (m_wr) begin e_dat = int'(m_wdata); e_oe = 1; end
            else begin e_oe = 0; e_rev = 0; end
        end
        cmp("state_demux", int'(state_demux), e_st);
        cmp("counter_demux", int'(counter_demux), e_cnt);
        if (!(e_st == 3 && !m_wr)) cmp("ex_bus_data_o", int'(ex_bus_data_o), e_dat);
        cmp("ex_bus_data_oe", int'(ex_bus_data_oe), e_oe);
        cmp("reverse_n", int'(ex_bus_data_reverse_n), e_rev);
        cmp("latch_demux", int'(latch_demux), e_lat);
        cmp("latch_demux_hi", int'(latch_demux_hi), e_hi);
        cmp("bus_data_out", int'(bus_data_out), int'(m_dout));
        cmp("bus_data_valid", int'(bus_data_valid), int'(m_valid));
    end

    task automatic idle_bus();
        bus_mreq_n = 1'b1; bus_iorq_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_108m);
        end
        #1;
    endtask

    // Memory read held for 'hold' cycles with literal timing checks.
    task automatic run_read(input logic [15:0] a, input logic [7:0] d, input int hold);
        bus_addr = a; ex_bus_data_i = d; bus_mreq_n = 1'b0; bus_rd_n = 1'b0;
        for (int j = 1; j <= hold + 2; j++) begin
            @(negedge clk_108m);
            if (j == 2) cmp("rd_latch_pre", int'(latch_demux), 0);
            if (j == 3 || j == 5) begin
                cmp("rd_latch_on", int'(latch_demux), 1);
                cmp("rd_addr_lo", int'(ex_bus_data_o), int'(a[7:0]));
            end
            if (j == 6) cmp("rd_latch_off", int'(latch_demux), 0);
            if (j == 11 || j == 13) begin
                cmp("rd_latch_hi_on", int'(latch_demux_hi), 1);
                cmp("rd_addr_hi", int'(ex_bus_data_o), int'(a[15:8]));
            end
            if (j == 16) cmp("rd_rev_pre", int'(ex_bus_data_reverse_n), 1);
            if (j == 17) cmp("rd_rev_data", int'(ex_bus_data_reverse_n), 0);
            if (j == 24) cmp("rd_valid_pre", int'(bus_data_valid), 0);
            if (j == 25) begin
                cmp("rd_valid", int'(bus_data_valid), 1);
                cmp("rd_data", int'(bus_data_out), int'(d));
            end
            if (j == 26) cmp("rd_valid_post", int'(bus_data_valid), 0);
            #1;
            if (j == hold) idle_bus();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        bus_addr = 16'h0000; bus_data_in = 8'h00; ex_bus_data_i = 8'h00;
        gap(2);
        cmp("rst_state", int'(state_demux), 0);
        cmp("rst_rev", int'(ex_bus_data_reverse_n), 1);
        reset = 1'b0;
        gap(3);

        // Read with defaults.
        run_read(16'h4A5B, 8'hC3, 40);
        gap(3);

        // I/O write.
        bus_addr = 16'h0098; bus_data_in = 8'h7E; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk_108m);
            if (j == 20) begin
                cmp("wr_data", int'(ex_bus_data_o), 8'h7E);
                cmp("wr_oe", int'(ex_bus_data_oe), 1);
            end
            if (j == 30) cmp("wr_oe_held", int'(ex_bus_data_oe), 1);
            if (j == 31) begin
                cmp("wr_oe_off", int'(ex_bus_data_oe), 0);
                cmp("wr_idle", int'(state_demux), 0);
            end
            if (j == 25) cmp("wr_no_valid", int'(bus_data_valid), 0);
            #1;
            if (j == 30) idle_bus();
        end
        gap(3);

        // Refresh cycles are ignored.
        bus_mreq_n = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk_108m);
            if (j == 10) cmp("refresh_state", int'(state_demux), 0);
            #1;
        end
        idle_bus();
        gap(3);

        // Aborted read.
        bus_addr = 16'h1234; ex_bus_data_i = 8'h55; bus_mreq_n = 1'b0; bus_rd_n = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk_108m);
            if (j == 11) cmp("abort_idle", int'(state_demux), 0);
            if (j == 30) cmp("abort_keep_data", int'(bus_data_out), 8'hC3);
            #1;
            if (j == 10) idle_bus();
        end
        gap(2);

        // Reset mid-transfer.
        bus_addr = 16'h4A5B; ex_bus_data_i = 8'h99; bus_mreq_n = 1'b0; bus_rd_n = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk_108m);
            if (j == 12) cmp("rst_mid_hi_before", int'(latch_demux_hi), 1);
            #1;
        end
        reset = 1'b1;
        #1;
        cmp("rst_mid_state", int'(state_demux), 0);
        cmp("rst_mid_counter", int'(counter_demux), 0);
        cmp("rst_mid_latch_hi", int'(latch_demux_hi), 0);
        cmp("rst_mid_oe", int'(ex_bus_data_oe), 0);
        cmp("rst_mid_data_o", int'(ex_bus_data_o), 0);
        cmp("rst_mid_rev", int'(ex_bus_data_reverse_n), 1);
        cmp("rst_mid_dout", int'(bus_data_out), 0);
        @(negedge clk_108m); #1;
        idle_bus();
        reset = 1'b0;
        gap(3);
        run_read(16'h4A5B, 8'hC3, 40);
        gap(3);

        // Back-to-back reads separated by one idle cycle.
        bus_addr = 16'h2000; ex_bus_data_i = 8'h11; bus_mreq_n = 1'b0; bus_rd_n = 1'b0;
        for (int j = 1; j <= 54; j++) begin
            @(negedge clk_108m);
            if (j == 25) begin
                cmp("b2b_valid1", int'(bus_data_valid), 1);
                cmp("b2b_data1", int'(bus_data_out), 8'h11);
            end
            if (j == 50) cmp("b2b_gap", int'(bus_data_valid), 0);
            if (j == 51) begin
                cmp("b2b_valid2", int'(bus_data_valid), 1);
                cmp("b2b_data2", int'(bus_data_out), 8'h22);
            end
            #1;
            if (j == 25) begin idle_bus(); ex_bus_data_i = 8'h22; end
            if (j == 26) begin bus_mreq_n = 1'b0; bus_rd_n = 1'b0; end
            if (j == 52) idle_bus();
        end
        gap(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
